// File: rtl/symbol_pkg.sv
// Shared symbol definitions for the 2-bit line code, used by both the
// encoder and the decoder sides of the link.
package symbol_pkg;

    // Line symbol codes
    localparam logic [1:0] SYM_ILLEGAL = 2'd0;
    localparam logic [1:0] SYM_FILL    = 2'd1;
    localparam logic [1:0] SYM_ONE     = 2'd2;
    localparam logic [1:0] SYM_ZERO    = 2'd3;

    // Receiver sync state
    typedef enum logic {
        HUNT   = 1'b0,
        LOCKED = 1'b1
    } sym_state_t;

    // Map a data symbol to its bit value (only meaningful for SYM_ONE/SYM_ZERO)
    function automatic logic sym_to_bit(input logic [1:0] sym);
        return (sym == SYM_ONE);
    endfunction

endpackage

// File: rtl/symbol_decoder_if.sv
// Handshake bundle for symbol_decoder: symbol input stream, decoded bit
// output stream and status/error outputs.
interface symbol_decoder_if;

    logic       in_valid;
    logic [1:0] in_sym;
    logic       in_ready;
    logic       out_valid;
    logic       out_bit;
    logic       out_ready;
    logic       locked;
    logic       err_pulse;
    logic [7:0] err_count;

    // Upstream/downstream environment side
    modport master (
        output in_valid, in_sym, out_ready,
        input  in_ready, out_valid, out_bit, locked, err_pulse, err_count
    );

    // Decoder side
    modport slave (
        input  in_valid, in_sym, out_ready,
        output in_ready, out_valid, out_bit, locked, err_pulse, err_count
    );

endinterface

// File: rtl/sym_fifo.sv
// Small 1-bit-wide synchronous FIFO with wrapping pointers and an
// occupancy count. Head entry is presented combinationally on o_dout
// (forced to 0 while empty so the output is defined after reset).
module sym_fifo #(
    parameter  int DEPTH = 4,
    localparam int AW    = $clog2(DEPTH),
    localparam int CW    = $clog2(DEPTH) + 1
) (
    input  logic          i_clk,
    input  logic          i_rst_n,
    input  logic          i_push,
    input  logic          i_din,
    input  logic          i_pop,
    output logic          o_dout,
    output logic [CW-1:0] o_count,
    output logic          o_full,
    output logic          o_empty
);

    logic          r_mem [DEPTH];
    logic [AW-1:0] r_wr_ptr;
    logic [AW-1:0] r_rd_ptr;
    logic [CW-1:0] r_count;
    logic          w_push;
    logic          w_pop;

    assign o_full   = (r_count == CW'(DEPTH));
    assign o_empty  = (r_count == '0);
    assign o_count  = r_count;
    assign w_push   = i_push && !o_full;
    assign w_pop    = i_pop && !o_empty;
    assign o_dout   = o_empty ? 1'b0 : r_mem[r_rd_ptr];

    // Storage write; contents need no reset since count gates visibility
    always_ff @(posedge i_clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= i_din;
        end
    end

    // Pointer and occupancy tracking; power-of-two depth gives natural wrap
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

endmodule

// File: rtl/symbol_decoder.sv
// Receive-side 2-bit symbol decoder: hunts for fill-symbol sync, maps data
// symbols to bits into an output FIFO, flags and counts illegal symbols.
// Optional feature macro: SYMBOL_DECODER_ERRCNT_EN enables the 8-bit
// saturating illegal-symbol counter (otherwise err_count reads 0).
module symbol_decoder
    import symbol_pkg::*;
#(
    parameter int DEPTH    = 4,
    parameter int SYNC_LEN = 3
) (
    input  logic            i_clk,
    input  logic            i_rst_n,
    symbol_decoder_if.slave bus
);

    localparam int         CW         = $clog2(DEPTH) + 1;
    localparam logic [3:0] SYNC_LEN_C = 4'(SYNC_LEN);

    sym_state_t    r_state;
    sym_state_t    w_state_next;
    logic [3:0]    r_sync_cnt;
    logic [3:0]    w_sync_next;
    logic          r_err_pulse;
    logic          w_accept;
    logic          w_push;
    logic          w_push_bit;
    logic          w_illegal;
    logic          w_fifo_full;
    logic          w_fifo_empty;
    logic [CW-1:0] w_fifo_count;

    // in_ready comes only from registered FIFO occupancy
    assign bus.in_ready  = !w_fifo_full;
    assign bus.out_valid = !w_fifo_empty;
    assign bus.locked    = (r_state == LOCKED);
    assign bus.err_pulse = r_err_pulse;
    assign w_accept      = bus.in_valid && !w_fifo_full;

    sym_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .i_clk   (i_clk),
        .i_rst_n (i_rst_n),
        .i_push  (w_push),
        .i_din   (w_push_bit),
        .i_pop   (bus.out_ready),
        .o_dout  (bus.out_bit),
        .o_count (w_fifo_count),
        .o_full  (w_fifo_full),
        .o_empty (w_fifo_empty)
    );

    // State and sync counter registers
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state    <= HUNT;
            r_sync_cnt <= '0;
        end else begin
            r_state    <= w_state_next;
            r_sync_cnt <= w_sync_next;
        end
    end

    // Next-state, sync counting, push and illegal-symbol detection
    always_comb begin
        w_state_next = r_state;
        w_sync_next  = r_sync_cnt;
        w_push       = 1'b0;
        w_push_bit   = sym_to_bit(bus.in_sym);
        w_illegal    = 1'b0;
        if (w_accept) begin
            case (r_state)
                HUNT: begin
                    case (bus.in_sym)
                        SYM_FILL: begin
                            if (r_sync_cnt + 4'd1 == SYNC_LEN_C) begin
                                w_state_next = LOCKED;
                                w_sync_next  = '0;
                            end else begin
                                w_sync_next  = r_sync_cnt + 4'd1;
                            end
                        end
                        SYM_ONE, SYM_ZERO: begin
                            // data before lock is discarded
                            w_sync_next = '0;
                        end
                        default: begin
                            w_sync_next = '0;
                            w_illegal   = 1'b1;
                        end
                    endcase
                end
                LOCKED: begin
                    case (bus.in_sym)
                        SYM_ONE, SYM_ZERO: begin
                            w_push = 1'b1;
                        end
                        SYM_FILL: begin
                            // idle fill while locked carries no data
                        end
                        default: begin
                            w_illegal    = 1'b1;
                            w_state_next = HUNT;
                            w_sync_next  = '0;
                        end
                    endcase
                end
                default: begin
                    w_state_next = HUNT;
                    w_sync_next  = '0;
                end
            endcase
        end
    end

    // One-cycle registered error strobe per accepted illegal symbol
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_err_pulse <= 1'b0;
        end else begin
            r_err_pulse <= w_illegal;
        end
    end

`ifdef SYMBOL_DECODER_ERRCNT_EN
    logic [7:0] r_err_count;

    // Saturating illegal-symbol counter
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_err_count <= 8'd0;
        end else if (w_illegal && (r_err_count != 8'hFF)) begin
            r_err_count <= r_err_count + 8'd1;
        end
    end

    assign bus.err_count = r_err_count;
`else
    assign bus.err_count = 8'd0;
`endif

endmodule

// File: doc/symbol_decoder.md
# symbol_decoder

Receive-side counterpart of the 2-bit symbol encoder. Accepts a stream of 2-bit line symbols over a valid/ready handshake, hunts for fill-symbol sync, and maps data symbols back to single bits. Decoded bits are buffered in a small FIFO and delivered over a second valid/ready handshake. Illegal symbols are flagged and counted.

## Interface
- DEPTH, 4: output FIFO depth in entries; power of two, ≥2.
- SYNC_LEN, 3: consecutive fill symbols needed to reach lock; 1..15.
- clock  in  1  single clock for the block; all state updates on the rising edge.
- reset  in  1  asynchronous, active-low; clears all state immediately.
- in_valid  in  1  a symbol is presented on in_sym.
- in_sym  in  2  line symbol: 2'd2 = bit 1, 2'd3 = bit 0, 2'd1 = fill, 2'd0 = illegal.
- in_ready  out  1  block accepts in_sym this cycle.
- out_valid  out  1  out_bit holds a decoded bit.
- out_bit  out  1  head-of-FIFO decoded bit.
- out_ready  in  1  downstream consumes out_bit this cycle.
- locked  out  1  decoder in LOCKED state.
- err_pulse  out  1  one-cycle pulse, registered, on an accepted illegal symbol.
- err_count  out  8  saturating count of illegal symbols.

## Operation
- Symbol accepted when in_valid && in_ready. Bit popped when out_valid && out_ready.
- in_ready = (fifo_count != DEPTH). It depends only on registered state, not on out_ready.
- FSM with two states, HUNT (reset state) and LOCKED:
  - In HUNT, fill increments sync_cnt (4 bits). Reaching SYNC_LEN moves to LOCKED and clears sync_cnt.
  - In HUNT, a data symbol clears sync_cnt and is discarded. An illegal symbol clears sync_cnt, pulses err_pulse and increments err_count.
  - In LOCKED, a data symbol pushes its bit (2→1, 3→0). Fill is dropped with no push. An illegal symbol pushes nothing, pulses err_pulse, increments err_count and returns to HUNT.
- FIFO: DEPTH entries with wrapping read/write pointers and a count of width $clog2(DEPTH)+1.
  - Push and pop in the same cycle leave the count unchanged. Both pointers advance, with mod-DEPTH wrap.
  - out_valid = (count != 0). out_bit is the entry at the read pointer.
- err_count saturates at 255 and never wraps.
- Unaccepted symbols (in_valid with !in_ready) have no effect on the FSM, sync_cnt or errors.
- Reset values: state HUNT, sync_cnt 0, FIFO empty, pointers 0, in_ready 1, out_valid 0, out_bit 0, locked 0, err_pulse 0, err_count 0.
- Reset mid-stream discards buffered bits. After deassertion the first symbol is evaluated in HUNT.

## Timing
- Latency: a data symbol accepted at edge N gives out_valid=1 after edge N (visible in cycle N+1). This holds when the FIFO was empty.
- locked rises in the cycle after the SYNC_LEN-th fill is accepted.
- locked falls in the cycle after an illegal symbol is accepted in LOCKED.
- err_pulse is high for exactly the cycle after each accepted illegal symbol. Back-to-back illegal symbols keep it high on consecutive cycles.
- Full throughput: one symbol in and one bit out per cycle in steady state.
- When full, in_ready deasserts. The next cycle with a pop reasserts it; there is no same-cycle pass-through.

## Configuration
- SYMBOL_DECODER_ERRCNT_EN defined: the 8-bit saturating err_count register is implemented as described.
- SYMBOL_DECODER_ERRCNT_EN undefined: there is no counter register, and err_count is tied to 8'd0. err_pulse and the HUNT return on illegal symbols are unchanged.

## Structure
- Shared package symbol_pkg:
  - Symbol code constants SYM_ILLEGAL=2'd0, SYM_FILL=2'd1, SYM_ONE=2'd2, SYM_ZERO=2'd3. These are shared with the encoder.
  - typedef sym_state_t {HUNT, LOCKED}.
- One sub-module: sym_fifo, a parameterised 1-bit-wide sync FIFO with push/pop/count/full/empty. symbol_decoder owns the FSM, mapping and error logic.

## Test plan
- Reset, then 3 fill symbols → locked=1 in cycle after third accept. Then symbols 2,3,3,2 with out_ready=1 → out_bit sequence 1,0,0,1, each one cycle after its symbol.
- Unlocked: symbols 2,1,1,3,1,1,1 → no out_valid until after the final three fills. Data before lock is discarded; locked rises once.
- Locked, out_ready=0: push 4 data symbols → count 4, in_ready=0, fifth symbol held. Raise out_ready → in_ready=1 next cycle, no bits lost, order preserved.
- Locked, symbol 0 → err_pulse for one cycle, err_count=1, locked=0 next cycle. Buffered bits still drain.
- With SYMBOL_DECODER_ERRCNT_EN: 260 illegal symbols → err_count=255. Without the macro → err_count=0 and err_pulse still seen.
- Assert reset mid-stream with 3 buffered bits → out_valid=0, in_ready=1, locked=0 immediately. No stale bits after release.
